// File: rtl/ebreak_halt_ctrl.sv
// Halt controller: an ebreak drains the LSU, reports once, then freezes the core; a watchdog reports a stall-out.
// Ebreak to halt_valid takes 2 cycles, plus one cycle per cycle that lsu_busy is held.
module ebreak_halt_ctrl #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 64,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic             isEbreak,
  input  logic [XLEN-1:0]  commit_pc,
  input  logic [XLEN-1:0]  a0,
  input  logic             lsu_busy,
  output logic             stall_req,
  output logic             halt_valid,
  output logic [XLEN-1:0]  halt_code,
  output logic [XLEN-1:0]  halt_pc,
  output logic             halt_good,
  output logic             halt_timeout,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALTED} state_t;

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [XLEN-1:0]   last_pc;
  logic              eb_commit;
  logic              wd_fire;

  assign eb_commit = commit_valid && isEbreak;
  // A commit in the firing cycle clears the idle count, so it always beats the watchdog.
  assign wd_fire   = (TIMEOUT != 0) && !commit_valid &&
                     (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (eb_commit)    state_nxt = DRAIN;
        else if (wd_fire) state_nxt = REPORT;
      end
      DRAIN:   if (!lsu_busy) state_nxt = REPORT;
      REPORT:  state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_req  = (state != RUN);
    halt_valid = (state == REPORT);
    halted     = (state == HALTED);
    halt_good  = ((state == REPORT) || (state == HALTED)) &&
                 (halt_code == '0) && !halt_timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt     <= '0;
      last_pc      <= '0;
      halt_code    <= '0;
      halt_pc      <= '0;
      halt_timeout <= 1'b0;
      cycle_cnt    <= '0;
      retire_cnt   <= '0;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (commit_valid) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        last_pc    <= commit_pc;
        idle_cnt   <= '0;
      end else if (TIMEOUT != 0) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
      if (eb_commit) begin
        halt_code <= a0;
        halt_pc   <= commit_pc;
      end else if (wd_fire) begin
        halt_code    <= '1;
        halt_pc      <= last_pc;
        halt_timeout <= 1'b1;
      end
    end else if (state == DRAIN) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
// Bench for ebreak_halt_ctrl: table of halt scenarios scored through an expected-halt queue, plus reset/halted/wrap sequences.
module tb_ebreak_halt_ctrl;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic             commit_valid = 1'b0;
  logic             isEbreak = 1'b0;
  logic [XLEN-1:0]  commit_pc = '0;
  logic [XLEN-1:0]  a0 = '0;
  logic             lsu_busy = 1'b0;
  logic             stall_req, halt_valid, halt_good, halt_timeout, halted;
  logic [XLEN-1:0]  halt_code, halt_pc;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;

  ebreak_halt_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .isEbreak(isEbreak),
    .commit_pc(commit_pc), .a0(a0), .lsu_busy(lsu_busy), .stall_req(stall_req),
    .halt_valid(halt_valid), .halt_code(halt_code), .halt_pc(halt_pc),
    .halt_good(halt_good), .halt_timeout(halt_timeout), .halted(halted),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  typedef struct {
    int          ncommit;
    logic [31:0] cpc;
    int          nidle;
    bit          eb;
    logic [31:0] epc;
    logic [31:0] ea0;
    int          busy;
    logic [31:0] xcode;
    logic [31:0] xpc;
    bit          xgood;
    bit          xtmo;
  } row_t;

  typedef struct {
    int          cyc;
    logic [31:0] code;
    logic [31:0] pc;
    bit          good;
    bit          tmo;
    logic [3:0]  ccnt;
    logic [3:0]  rcnt;
  } exp_t;

  exp_t sbq[$];
  row_t rows[6];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit cv, input bit eb,
                      input logic [31:0] pc, input logic [31:0] av, input bit busy);
    @(posedge clk);
    #1;
    reset = rst; commit_valid = cv; isEbreak = eb;
    commit_pc = pc; a0 = av; lsu_busy = busy;
  endtask

  task automatic push(input int c, input logic [31:0] code, input logic [31:0] pc,
                      input bit good, input bit tmo, input int ccnt, input int rcnt);
    exp_t e;
    e.cyc = c; e.code = code; e.pc = pc; e.good = good; e.tmo = tmo;
    e.ccnt = 4'(ccnt); e.rcnt = 4'(rcnt);
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && halt_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_halt: halt_valid=1 with no halt expected (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("halt_cycle", cyc, e.cyc);
        chk("halt_code", halt_code, e.code);
        chk("halt_pc", halt_pc, e.pc);
        chk("halt_good", halt_good, e.good);
        chk("halt_timeout", halt_timeout, e.tmo);
        chk("cycle_cnt_at_halt", cycle_cnt, e.ccnt);
        chk("retire_cnt_at_halt", retire_cnt, e.rcnt);
        chk("stall_in_report", stall_req, 1);
      end
    end
  end

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_halt_valid", halt_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_code", halt_code, 0);
    chk("rst_pc", halt_pc, 0);
    chk("rst_good", halt_good, 0);
    chk("rst_timeout", halt_timeout, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
  endtask

  task automatic wait_halt();
    for (int k = 0; k < 30 && sbq.size() != 0; k++) step(0, 0, 0, 0, 0, 0);
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL halt_wait: %0d expected halts never seen", sbq.size());
      sbq.delete();
    end
    step(0, 0, 0, 0, 0, 0);
    chk("post_halt_valid", halt_valid, 0);
    chk("post_halted", halted, 1);
    chk("post_stall", stall_req, 1);
  endtask

  task automatic run_row(input row_t r);
    do_reset();
    for (int i = 0; i < r.ncommit; i++) begin
      step(0, 1, 0, r.cpc + 32'(4 * i), 32'h55, 0);
      chk("run_stall", stall_req, 0);
    end
    for (int i = 0; i < r.nidle; i++) step(0, 0, 0, 0, 0, 0);
    if (r.eb) begin
      step(0, 1, 1, r.epc, r.ea0, r.busy > 0);
      push(cyc + 2 + r.busy, r.xcode, r.xpc, r.xgood, r.xtmo,
           r.ncommit + r.nidle + 2 + r.busy, r.ncommit + 1);
      for (int i = 0; i < r.busy; i++) begin
        step(0, 0, 0, 0, 0, 1);
        chk("drain_stall", stall_req, 1);
      end
      step(0, 0, 0, 0, 0, 0);
    end else begin
      push(cyc + 1, r.xcode, r.xpc, r.xgood, r.xtmo, r.ncommit + r.nidle, r.ncommit);
    end
    wait_halt();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation ran too long");
    $fatal(1, "timeout");
  end

  initial begin
    rows[0] = '{5, 32'h80000000, 0, 1'b1, 32'h80000010, 32'h0, 0, 32'h0, 32'h80000010, 1'b1, 1'b0};
    rows[1] = '{2, 32'h2000, 0, 1'b1, 32'h3000, 32'h1, 4, 32'h1, 32'h3000, 1'b0, 1'b0};
    rows[2] = '{3, 32'hF8, 8, 1'b0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 32'h100, 1'b0, 1'b1};
    rows[3] = '{1, 32'h100, 7, 1'b1, 32'h200, 32'h3, 0, 32'h3, 32'h200, 1'b0, 1'b0};
    rows[4] = '{0, 32'h0, 8, 1'b0, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1};
    rows[5] = '{16, 32'h4000, 0, 1'b1, 32'h5000, 32'h0, 2, 32'h0, 32'h5000, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Reset while draining aborts the halt; a fresh ebreak then halts normally.
    do_reset();
    step(0, 1, 0, 32'h40, 0, 0);
    step(0, 1, 1, 32'h44, 32'h5, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("abort_drain_stall", stall_req, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("abort_code", halt_code, 0);
    chk("abort_pc", halt_pc, 0);
    chk("abort_stall", stall_req, 0);
    chk("abort_halted", halted, 0);
    chk("abort_cycle_cnt", cycle_cnt, 0);
    chk("abort_retire_cnt", retire_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("abort_no_halt", halt_valid, 0);
    end
    step(0, 1, 1, 32'h48, 32'h0, 0);
    push(cyc + 2, 32'h0, 32'h48, 1'b1, 1'b0, 6, 1);
    wait_halt();

    // Commits in HALTED are ignored and leave every result untouched.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 32'h999, 32'h7, 1);
      chk("halted_cycle_cnt", cycle_cnt, 6);
      chk("halted_retire_cnt", retire_cnt, 1);
      chk("halted_sticky", halted, 1);
      chk("halted_no_pulse", halt_valid, 0);
      chk("halted_code", halt_code, 0);
      chk("halted_pc", halt_pc, 32'h48);
      chk("halted_good", halt_good, 1);
    end

    // 4-bit counters wrap 15 -> 0.
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(0, 1, 0, 32'(k * 4), 0, 0);
      if (k == 16) begin
        chk("wrap_cycle_15", cycle_cnt, 15);
        chk("wrap_retire_15", retire_cnt, 15);
      end
      if (k == 17) begin
        chk("wrap_cycle_0", cycle_cnt, 0);
        chk("wrap_retire_0", retire_cnt, 0);
      end
    end

    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
